// File: rtl/cpu_step_sequencer_pkg.sv
// Shared phase codes and datapath widths
// for the trainer CPU step sequencer.
package cpu_step_sequencer_pkg;

  localparam int INSTR_W = 8;
  localparam int STEP_W  = 16;

  typedef enum logic [2:0] {
    PH_IDLE      = 3'd0,
    PH_FETCH     = 3'd1,
    PH_DECODE    = 3'd2,
    PH_EXECUTE   = 3'd3,
    PH_WRITEBACK = 3'd4
  } phase_e;

endpackage

// File: rtl/cpu_step_sequencer_btn_debounce.sv
// Button synchronizer, debouncer and
// one-cycle rising-edge step request.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic step_req
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          deb_d1_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      deb_q    <= 1'b0;
      deb_d1_q <= 1'b0;
      cnt_q    <= '0;
      step_req <= 1'b0;
    end else begin
      sync1_q  <= btn;
      sync2_q  <= sync1_q;
      deb_d1_q <= deb_q;
      step_req <= deb_q & ~deb_d1_q;
      // accept the new level on the last of the required differing samples
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_q <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_step_sequencer.sv
// Step sequencer: button or auto-run timer
// drives one FETCH/DECODE/EXECUTE/WRITEBACK pass.
module cpu_step_sequencer
  import cpu_step_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RUN_DIV         = 8,
  parameter int EXEC_TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step_btn,
  input  logic               run_mode,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               exec_done,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_load,
  output logic               reg_rd_en,
  output logic               alu_en,
  output logic               reg_wr_en,
  output logic               flag_wr_en,
  output logic               busy,
  output logic [2:0]         phase,
  output logic [STEP_W-1:0]  step_count,
  output logic               fault
);

  localparam int DW = $clog2(RUN_DIV + 1);
  localparam int TW = $clog2(EXEC_TIMEOUT + 1);

  phase_e              state_q;
  phase_e              state_d;
  logic                btn_req;
  logic                auto_req;
  logic                step_req;
  logic                tmo_hit;
  logic [DW-1:0]       div_q;
  logic [TW-1:0]       tmo_q;
  logic [INSTR_W-1:0]  ir_q;
  logic [STEP_W-1:0]   step_cnt_q;
  logic                fault_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (step_btn),
    .step_req (btn_req)
  );

  always_comb begin
    auto_req = (state_q == PH_IDLE) && run_mode
               && (div_q == DW'(RUN_DIV));
    step_req = run_mode ? auto_req : btn_req;
    tmo_hit  = (tmo_q == TW'(EXEC_TIMEOUT - 1));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PH_IDLE:      if (step_req) state_d = PH_FETCH;
      PH_FETCH:     state_d = PH_DECODE;
      PH_DECODE:    state_d = PH_EXECUTE;
      PH_EXECUTE: begin
        if (exec_done)    state_d = PH_WRITEBACK;
        else if (tmo_hit) state_d = PH_IDLE;
      end
      PH_WRITEBACK: state_d = PH_IDLE;
      default:      state_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PH_IDLE;
      div_q      <= '0;
      tmo_q      <= '0;
      ir_q       <= '0;
      step_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // divider only runs while idling in auto-run
      if (state_q == PH_IDLE && run_mode && !auto_req)
        div_q <= div_q + DW'(1);
      else
        div_q <= '0;
      if (state_q == PH_EXECUTE)
        tmo_q <= tmo_q + TW'(1);
      else
        tmo_q <= '0;
      if (state_q == PH_FETCH)
        ir_q <= instr_in;
      if (state_q == PH_WRITEBACK)
        step_cnt_q <= step_cnt_q + STEP_W'(1);
      if (state_q == PH_EXECUTE && !exec_done && tmo_hit)
        fault_q <= 1'b1;
    end
  end

  assign ir_load    = (state_q == PH_FETCH);
  assign reg_rd_en  = (state_q == PH_DECODE);
  assign alu_en     = (state_q == PH_EXECUTE);
  assign reg_wr_en  = (state_q == PH_WRITEBACK);
  assign flag_wr_en = (state_q == PH_WRITEBACK);
  assign busy       = (state_q != PH_IDLE);
  assign phase      = state_q;
  assign ir         = ir_q;
  assign step_count = step_cnt_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Directed bench for cpu_step_sequencer
// at default parameters.
module tb_cpu_step_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step_btn = 1'b0;
  logic        run_mode = 1'b0;
  logic [7:0]  instr_in = 8'h00;
  logic        exec_done = 1'b0;
  logic [7:0]  ir;
  logic        ir_load, reg_rd_en, alu_en;
  logic        reg_wr_en, flag_wr_en, busy;
  logic [2:0]  phase;
  logic [15:0] step_count;
  logic        fault;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int alu_cnt = 0;
  int wr_cnt = 0;
  int fetch_cyc[$];

  cpu_step_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_btn   (step_btn),
    .run_mode   (run_mode),
    .instr_in   (instr_in),
    .exec_done  (exec_done),
    .ir         (ir),
    .ir_load    (ir_load),
    .reg_rd_en  (reg_rd_en),
    .alu_en     (alu_en),
    .reg_wr_en  (reg_wr_en),
    .flag_wr_en (flag_wr_en),
    .busy       (busy),
    .phase      (phase),
    .step_count (step_count),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (alu_en) alu_cnt++;
    if (reg_wr_en) wr_cnt++;
    if (ir_load) fetch_cyc.push_back(cyc);
  end

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic wait_phase(logic [2:0] p, int max,
                            string tag);
    int n = 0;
    while (phase !== p && n < max) begin
      @(negedge clk);
      n++;
    end
    if (phase !== p) chk(tag, phase, p);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step_btn = 1'b0;
    run_mode = 1'b0;
    exec_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [14:0] seq;
    int n;

    // clean press
    do_reset();
    chk("rst_phase", phase, 3'd0);
    chk("rst_count", step_count, 16'h0000);
    chk("rst_misc",
        {ir, busy, fault, ir_load, reg_rd_en,
         alu_en, reg_wr_en, flag_wr_en}, 0);
    exec_done = 1'b1;
    instr_in = 8'hA5;
    step_btn = 1'b1;
    n = 0;
    while (phase !== 3'd1 && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("press_to_fetch", n, 20);
    chk("fetch_ir_load", ir_load, 1'b1);
    seq = {12'b0, phase};
    @(negedge clk);
    chk("ir_latched", ir, 8'hA5);
    seq = {seq[11:0], phase};
    repeat (3) begin
      @(negedge clk);
      seq = {seq[11:0], phase};
    end
    chk("phase_seq", seq, {3'd1, 3'd2, 3'd3, 3'd4, 3'd0});
    chk("count_one", step_count, 16'd1);
    chk("idle_busy", busy, 1'b0);
    step_btn = 1'b0;
    repeat (30) @(negedge clk);
    chk("release_none", step_count, 16'd1);

    // bouncing press then bouncing release
    for (int i = 0; i < 5; i++) begin
      step_btn = 1'b1;
      repeat (3) @(negedge clk);
      step_btn = 1'b0;
      repeat (3) @(negedge clk);
    end
    step_btn = 1'b1;
    repeat (40) @(negedge clk);
    chk("bounce_press", step_count, 16'd2);
    for (int i = 0; i < 5; i++) begin
      step_btn = 1'b0;
      repeat (3) @(negedge clk);
      step_btn = 1'b1;
      repeat (3) @(negedge clk);
    end
    step_btn = 1'b0;
    repeat (40) @(negedge clk);
    chk("bounce_release", step_count, 16'd2);

    // glitch one cycle short of acceptance, then exactly long enough
    step_btn = 1'b1;
    repeat (15) @(negedge clk);
    step_btn = 1'b0;
    repeat (30) @(negedge clk);
    chk("glitch_15", step_count, 16'd2);
    step_btn = 1'b1;
    repeat (16) @(negedge clk);
    step_btn = 1'b0;
    repeat (30) @(negedge clk);
    chk("pulse_16", step_count, 16'd3);

    // press lands during a stretched EXECUTE
    rst_n = 1'b0;
    step_btn = 1'b0;
    repeat (2) @(negedge clk);
    run_mode = 1'b1;
    exec_done = 1'b0;
    step_btn = 1'b1;
    alu_cnt = 0;
    wr_cnt = 0;
    rst_n = 1'b1;
    wait_phase(3'd3, 40, "exec_reach");
    run_mode = 1'b0;
    repeat (10) @(negedge clk);
    exec_done = 1'b1;
    wait_phase(3'd0, 20, "exec_leave");
    repeat (40) @(negedge clk);
    chk("exec_alu_cycles", alu_cnt, 11);
    chk("exec_drop_count", step_count, 16'd1);
    chk("exec_no_fault", fault, 1'b0);

    // execute timeout
    do_reset();
    alu_cnt = 0;
    wr_cnt = 0;
    step_btn = 1'b1;
    wait_phase(3'd3, 40, "tmo_reach");
    wait_phase(3'd0, 100, "tmo_leave");
    repeat (5) @(negedge clk);
    chk("tmo_alu_cycles", alu_cnt, 64);
    chk("tmo_fault", fault, 1'b1);
    chk("tmo_phase", phase, 3'd0);
    chk("tmo_count", step_count, 16'd0);
    chk("tmo_no_wb", wr_cnt, 0);
    step_btn = 1'b0;
    repeat (25) @(negedge clk);
    exec_done = 1'b1;
    step_btn = 1'b1;
    repeat (30) @(negedge clk);
    chk("tmo_then_step", step_count, 16'd1);
    chk("fault_sticky", fault, 1'b1);

    // auto-run spacing and stop
    do_reset();
    exec_done = 1'b1;
    run_mode = 1'b1;
    fetch_cyc.delete();
    repeat (60) @(negedge clk);
    chk("auto_fetches", fetch_cyc.size(), 4);
    if (fetch_cyc.size() >= 4) begin
      for (int i = 1; i < 4; i++)
        chk("auto_gap",
            fetch_cyc[i] - fetch_cyc[i-1], 13);
    end
    wait_phase(3'd2, 20, "auto_decode");
    run_mode = 1'b0;
    repeat (40) @(negedge clk);
    chk("auto_stop_fetch", fetch_cyc.size(), 5);
    chk("auto_stop_count", step_count, 16'd5);

    // async reset mid-instruction, then counter wrap
    do_reset();
    exec_done = 1'b1;
    instr_in = 8'h3C;
    step_btn = 1'b1;
    wait_phase(3'd2, 40, "rst_decode");
    chk("pre_rst_ir", ir, 8'h3C);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_phase", phase, 3'd0);
    chk("mid_rst_outs",
        {ir, busy, fault, ir_load, reg_rd_en,
         alu_en, reg_wr_en, flag_wr_en}, 0);
    step_btn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    force dut.step_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.step_cnt_q;
    @(negedge clk);
    chk("preload", step_count, 16'hFFFF);
    step_btn = 1'b1;
    repeat (30) @(negedge clk);
    chk("wrap", step_count, 16'h0000);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
